run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 20 ++
 rtl/run_controller.sv | 119 +++++++++++
 tb/tb_run_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the run controller.
package run_ctrl_pkg;

    localparam int unsigned RST_HOLD_DEF   = 4;
    localparam int unsigned MAX_CYCLES_DEF = 10;
    localparam int unsigned CNT_W_DEF      = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_STEP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Processor-core run controller: reset hold, free run, single step, budgeted stop.
// Optional stall counting is enabled by defining RUN_CTRL_PERF_EN.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD   = RST_HOLD_DEF,
    parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_in,
    input  logic             stall_in,
    output logic             core_rst,
    output logic             core_en,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned       HOLD_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic              launch_c;
    logic              timeout_n;

    // Next-state decode; launch_c clears the run counters on the same edge.
    always_comb begin
        state_n   = state;
        timeout_n = timeout;
        launch_c  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n   = S_HOLD;
                    timeout_n = 1'b0;
                    launch_c  = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = step_mode ? S_PAUSE : S_RUN;
                end
            end
            S_RUN, S_STEP: begin
                if (halt_in) begin
                    state_n   = S_DONE;
                    timeout_n = 1'b0;
                end else if (cycle_cnt == LAST_CYCLE) begin
                    state_n   = S_DONE;
                    timeout_n = 1'b1;
                end else if ((state == S_STEP) || step_mode) begin
                    state_n = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!step_mode) begin
                    state_n = S_RUN;
                end else if (step) begin
                    state_n = S_STEP;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and Moore outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
            core_rst <= (state_n == S_IDLE) || (state_n == S_HOLD);
            core_en  <= (state_n == S_RUN) || (state_n == S_STEP);
            running  <= (state_n == S_RUN) || (state_n == S_PAUSE) || (state_n == S_STEP);
            done     <= (state_n == S_DONE);
            timeout  <= timeout_n;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch_c),
        .inc   (core_en),
        .count (cycle_cnt)
    );

`ifdef RUN_CTRL_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch_c),
        .inc   (core_en && stall_in),
        .count (stall_cnt)
    );
`else
    logic unused_stall_in;
    assign unused_stall_in = stall_in;
    assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller (RST_HOLD=4, MAX_CYCLES=10).
module tb_run_controller;

    localparam int unsigned RST_HOLD   = 4;
    localparam int unsigned MAX_CYCLES = 10;
    localparam int unsigned CNT_W      = 32;
`ifdef RUN_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, step_mode, step, halt_in, stall_in;
    logic             core_rst, core_en, running, done, timeout;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    run_controller #(
        .RST_HOLD   (RST_HOLD),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .halt_in   (halt_in),
        .stall_in  (stall_in),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .running   (running),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt)
    );

    // Reference model: where the run is, expressed as flags and counts.
    bit      m_idle, m_run, m_pause, m_stepping, m_done, m_to;
    int      m_hold_left;
    longint  m_cyc, m_stall;

    task automatic m_edge();
        if (rst) begin
            m_idle = 1; m_run = 0; m_pause = 0; m_stepping = 0; m_done = 0;
            m_to = 0; m_hold_left = 0; m_cyc = 0; m_stall = 0;
        end else if ((m_idle || m_done) && start) begin
            m_idle = 0; m_done = 0; m_to = 0; m_cyc = 0; m_stall = 0;
            m_hold_left = RST_HOLD;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                if (step_mode) m_pause = 1; else m_run = 1;
            end
        end else if (m_run || m_stepping) begin
            m_cyc++;
            if (PERF && stall_in) m_stall++;
            if (halt_in || m_cyc == MAX_CYCLES) begin
                m_run = 0; m_stepping = 0; m_done = 1; m_to = !halt_in;
            end else if (m_stepping || step_mode) begin
                m_run = 0; m_stepping = 0; m_pause = 1;
            end
        end else if (m_pause) begin
            if (!step_mode) begin
                m_pause = 0; m_run = 1;
            end else if (step) begin
                m_pause = 0; m_stepping = 1;
            end
        end
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_flags(input string name, input logic [4:0] exp);
        chk(name, 64'({core_rst, core_en, running, done, timeout}), 64'(exp));
    endtask

    task automatic do_reset();
        rst = 1; start = 0; step = 0; halt_in = 0; stall_in = 0;
        tick();
        rst = 0;
    endtask

    // Reset, then start: leaves the DUT in its first post-HOLD cycle.
    task automatic launch();
        do_reset();
        start = 1;
        tick();
        start = 0;
        repeat (RST_HOLD) tick();
    endtask

    typedef struct {
        logic        rst, start, halt;
        logic [4:0]  flags;   // core_rst, core_en, running, done, timeout
        logic [31:0] cnt;
    } vec_t;

    localparam int unsigned NV = 17;
    vec_t tbl[NV];

    initial begin
        int en_cycles;

        // Full timeout run: reset, start, 4 HOLD cycles, 10 RUN cycles, DONE.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 5'b10000, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 5'b10000, 32'd0};
        for (int i = 2; i <= 4; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 5'b10000, 32'd0};
        for (int i = 5; i <= 14; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 5'b01100, 32'(i - 5)};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 5'b00011, 32'd10};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 5'b00011, 32'd10};

        rst = 1; start = 0; step_mode = 0; step = 0; halt_in = 0; stall_in = 0;
        for (int i = 0; i < int'(NV); i++) begin
            rst = tbl[i].rst; start = tbl[i].start; halt_in = tbl[i].halt;
            tick();
            chk_flags($sformatf("tbl%0d_flags", i), tbl[i].flags);
            chk($sformatf("tbl%0d_cnt", i), 64'(cycle_cnt), 64'(tbl[i].cnt));
        end
        halt_in = 0;

        // Halt in the 6th enabled cycle.
        launch();
        repeat (5) tick();
        chk("halt6_pre_cnt", 64'(cycle_cnt), 64'd5);
        halt_in = 1;
        tick();
        halt_in = 0;
        chk_flags("halt6_flags", 5'b00010);
        chk("halt6_cnt", 64'(cycle_cnt), 64'd6);
        tick();
        chk_flags("halt6_after", 5'b00010);

        // Halt coincident with budget expiry: halt wins.
        launch();
        repeat (MAX_CYCLES - 1) tick();
        halt_in = 1;
        tick();
        halt_in = 0;
        chk_flags("halt_at_budget_flags", 5'b00010);
        chk("halt_at_budget_cnt", 64'(cycle_cnt), 64'd10);

        // Single step: 3 spaced pulses, then release to RUN.
        step_mode = 1;
        launch();
        chk_flags("step_pause", 5'b00100);
        en_cycles = 0;
        for (int p = 0; p < 3; p++) begin
            repeat (2) begin tick(); en_cycles += int'(core_en); end
            step = 1;
            tick(); en_cycles += int'(core_en);
            step = 0;
            tick(); en_cycles += int'(core_en);
        end
        chk("step_en_cycles", 64'(en_cycles), 64'd3);
        chk("step_cnt", 64'(cycle_cnt), 64'd3);
        step_mode = 0;
        en_cycles = 0;
        repeat (7) begin tick(); en_cycles += int'(core_en); end
        chk("step_release_en", 64'(en_cycles), 64'd7);
        tick();
        chk_flags("step_release_done", 5'b00011);
        chk("step_release_cnt", 64'(cycle_cnt), 64'd10);

        // Start ignored in RUN; reset mid-run.
        launch();
        repeat (3) tick();
        start = 1;
        tick();
        start = 0;
        chk_flags("start_in_run", 5'b01100);
        chk("start_in_run_cnt", 64'(cycle_cnt), 64'd4);
        rst = 1;
        tick();
        rst = 0;
        chk_flags("rst_in_run", 5'b10000);
        chk("rst_in_run_cnt", 64'(cycle_cnt), 64'd0);

        // Stall counting on 4 of 10 enabled cycles, then restart from DONE clears.
        launch();
        for (int i = 0; i < 10; i++) begin
            stall_in = (i % 3 == 0);
            tick();
        end
        stall_in = 0;
        chk_flags("stall_done", 5'b00011);
        chk("stall_cnt", 64'(stall_cnt), PERF ? 64'd4 : 64'd0);
        start = 1;
        tick();
        start = 0;
        chk_flags("restart_flags", 5'b10000);
        chk("restart_cnt", 64'({cycle_cnt, stall_cnt}), 64'd0);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(63) == 0);
            start    = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) step_mode = ~step_mode;
            step     = ($urandom_range(3) == 0);
            halt_in  = ($urandom_range(15) == 0);
            stall_in = $urandom_range(1) == 1;
            tick();
            chk("rand_flags", 64'({core_rst, core_en, running, done, timeout}),
                64'({m_idle || (m_hold_left > 0), m_run || m_stepping,
                     m_run || m_pause || m_stepping, m_done, m_to}));
            chk("rand_cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            chk("rand_stall_cnt", 64'(stall_cnt), 64'(m_stall));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
